spoofer_avst_gen: RTL
=====================

# spoofer_avst_gen

Parametrised multi-channel Avalon-ST test-pattern source for bench and bring-up use. Generates framed packets (SOP/EOP) of configurable length, round-robin over CHANNELS logical channels, with back-to-back streaming, programmable inter-packet gap and selectable data pattern. It replaces the single-beat spoofer wrapper as the stimulus source feeding any AVST sink in the FPGA datapath.

## Interface
- DATA_WIDTH, 32, width of data bus (>= 8)
- CHANNELS, 4, number of logical channels (>= 1); CH_W = max(1, $clog2(CHANNELS))
- PKT_LEN, 16, beats per packet (>= 1)
- GAP_CYCLES, 0, idle cycles (valid low) inserted between packets (>= 0)
- LFSR_TAPS, 32'h80200003, Galois LFSR feedback mask (low DATA_WIDTH bits used)

- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  start/continue generation; sampled at packet boundaries
- mode  in  2  pattern: 00 counter, 01 LFSR, 10 walking-one, 11 reserved (acts as 00)
- ready  in  1  AVST ready from sink, ready latency 0
- valid  out  1  AVST valid
- data  out  DATA_WIDTH  AVST data
- channel  out  CH_W  channel of current packet
- sop  out  1  first beat of packet
- eop  out  1  last beat of packet
- pkt_count  out  16  completed packets since reset, wraps at 2^16

## Operation
- One clock; reset is asynchronous and active-high. All outputs registered.
- Reset values: valid 0, data 0, channel 0, sop 0, eop 0, pkt_count 0; state IDLE; beat index 0; channel pointer 0; all per-channel counters 0; all per-channel LFSRs 1.
- States: IDLE, SEND, GAP.
  - IDLE: valid 0. enable=1 -> load first beat of packet for current channel, go SEND.
  - SEND: valid 1. Beat accepted when valid && ready. On non-last accept: advance beat index, load next beat. On last accept (eop): pkt_count+1, channel pointer +1 (wraps CHANNELS-1 -> 0); then GAP if GAP_CYCLES>0, else if enable load next packet's first beat and stay SEND (no bubble), else IDLE.
  - GAP: valid 0, count GAP_CYCLES cycles, then IDLE-entry rule applies (enable=1 -> SEND with first beat loaded, else IDLE).
- mode latched at packet start; changes mid-packet ignored.
- Patterns (per channel, state persists across packets of that channel):
  - counter: data = channel counter; counter +1 per accepted beat, wraps at 2^DATA_WIDTH.
  - LFSR: data = channel LFSR; per accepted beat: lsb ? (lfsr>>1)^LFSR_TAPS : lfsr>>1.
  - walking-one: data = 1 << (beat index mod DATA_WIDTH).
- Backpressure: while valid && !ready, data, channel, sop, eop held stable; no state advances.
- enable deassert mid-packet does not truncate; current packet completes, then IDLE.
- PKT_LEN=1: sop and eop asserted on same beat.
- Reset mid-packet: outputs go to reset values immediately; packet abandoned, not counted; restart at channel 0 with fresh pattern state.

## Timing
- Start latency: enable sampled 1 in IDLE at edge N -> valid=1 after edge N (first beat visible cycle N+1).
- Throughput: one beat per cycle with ready=1, including across packet boundaries when GAP_CYCLES=0.
- Gap: exactly GAP_CYCLES cycles with valid 0 between eop accept and next sop when enable held 1, plus one IDLE-to-SEND load cycle only if enable was 0 at gap end.
- pkt_count updates on the edge that accepts eop.

## Configuration
- SPOOFER_AVST_LFSR_EN: defined -> per-channel LFSR registers built, mode 01 yields LFSR pattern. Undefined -> LFSR logic and registers omitted; mode 01 behaves as counter (00); LFSR_TAPS unused.

## Test plan
- Defaults, ready=1, enable=1, mode 00: ch0 data 0..15 (sop on 0, eop on 15), then ch1 0..15, ch2, ch3, then ch0 16..31; no valid gaps; pkt_count=4 after 64 beats.
- Backpressure: ready low 3 cycles at beat 5 of ch0 -> data=5, sop=0, eop=0 held 3 cycles, then beats 6..15 continue.
- GAP_CYCLES=2: valid low exactly 2 cycles between ch0 eop and ch1 sop.
- enable drops at beat 4 -> beats 5..15 still emitted, eop at 15, then valid stays 0, pkt_count=1.
- rst pulse at beat 7 of ch1 -> valid/data/sop/eop 0 immediately; after release with enable=1 first beat ch0 data 0, pkt_count 0.
- SPOOFER_AVST_LFSR_EN defined, mode 01: ch0 beats 0x00000001, 0x80200003, 0xC0300002; macro undefined, same stimulus -> 0, 1, 2.

Source files
------------

// File: rtl/spoofer_avst_gen.sv
// rtl/spoofer_avst_gen.sv - multi-channel Avalon-ST packet pattern source
// Optional LFSR pattern built only when SPOOFER_AVST_LFSR_EN is defined.
module spoofer_avst_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter int          CHANNELS   = 4,
    parameter int          PKT_LEN    = 16,
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] LFSR_TAPS  = 32'h80200003,
    localparam int         CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CH_W-1:0]       channel,
    output logic                  sop,
    output logic                  eop,
    output logic [15:0]           pkt_count
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] MODE_CNT  = 2'b00;
    localparam logic [1:0] MODE_LFSR = 2'b01;
    localparam logic [1:0] MODE_WALK = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [1:0]              mode_q, mode_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CH_W-1:0]         chan_q, chan_d;
    logic                    sop_q, sop_d;
    logic                    eop_q, eop_d;
    logic [15:0]             pkt_q, pkt_d;
    logic [DATA_WIDTH-1:0]   cnt_q [CHANNELS];
    logic [DATA_WIDTH-1:0]   cnt_d [CHANNELS];

    logic                    load;
    logic [CH_W-1:0]         ld_ch;
    logic [BEAT_W-1:0]       ld_beat;
    logic [1:0]              ld_mode;
    logic [CH_W-1:0]         ch_next;

`ifdef SPOOFER_AVST_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(LFSR_TAPS);

    logic [DATA_WIDTH-1:0]   lfsr_q [CHANNELS];
    logic [DATA_WIDTH-1:0]   lfsr_d [CHANNELS];

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_CNT : m;
    endfunction
`else
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == MODE_WALK) ? MODE_WALK : MODE_CNT;
    endfunction
`endif

    assign ch_next = (int'(ch_q) == CHANNELS - 1) ? '0 : ch_q + 1'b1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ch_d    = ch_q;
        gap_d   = gap_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;
`ifdef SPOOFER_AVST_LFSR_EN
        lfsr_d  = lfsr_q;
`endif
        load    = 1'b0;
        ld_ch   = ch_q;
        ld_beat = beat_q;
        ld_mode = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    load    = 1'b1;
                    ld_beat = '0;
                    ld_mode = eff_mode(mode);
                end
            end
            ST_SEND: begin
                if (valid_q && ready) begin
                    // Pattern state advances only for the pattern actually in use.
                    if (mode_q == MODE_CNT)
                        cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
`ifdef SPOOFER_AVST_LFSR_EN
                    if (mode_q == MODE_LFSR)
                        lfsr_d[ch_q] = lfsr_step(lfsr_q[ch_q]);
`endif
                    if (int'(beat_q) != PKT_LEN - 1) begin
                        load    = 1'b1;
                        ld_beat = beat_q + 1'b1;
                    end else begin
                        pkt_d   = pkt_q + 1'b1;
                        ch_d    = ch_next;
                        beat_d  = '0;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else if (enable) begin
                            load    = 1'b1;
                            ld_ch   = ch_next;
                            ld_beat = '0;
                            ld_mode = eff_mode(mode);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (int'(gap_q) >= GAP_CYCLES - 1) begin
                    if (enable) begin
                        load    = 1'b1;
                        ld_beat = '0;
                        ld_mode = eff_mode(mode);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loads read the already-advanced pattern state so a one-channel
        // configuration continues seamlessly across packet boundaries.
        if (load) begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            beat_d  = ld_beat;
            chan_d  = ld_ch;
            mode_d  = ld_mode;
            sop_d   = (ld_beat == '0);
            eop_d   = (int'(ld_beat) == PKT_LEN - 1);
            case (ld_mode)
                MODE_WALK: data_d = DATA_WIDTH'(1) << (int'(ld_beat) % DATA_WIDTH);
`ifdef SPOOFER_AVST_LFSR_EN
                MODE_LFSR: data_d = lfsr_d[ld_ch];
`endif
                default:   data_d = cnt_d[ld_ch];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            ch_q    <= '0;
            gap_q   <= '0;
            mode_q  <= MODE_CNT;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            pkt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
`ifdef SPOOFER_AVST_LFSR_EN
                lfsr_q[i] <= DATA_WIDTH'(1);
`endif
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ch_q    <= ch_d;
            gap_q   <= gap_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
`ifdef SPOOFER_AVST_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign channel   = chan_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign pkt_count = pkt_q;

endmodule
